// File: rtl/sisc_fetch_unit_pkg.sv
// Shared definitions for the SISC fetch unit: opcodes, IR field positions,
// fetch FSM states and default parameters.
package sisc_fetch_unit_pkg;

   localparam int AW_DEF = 16;
   localparam int IW_DEF = 32;
   localparam logic [15:0] RST_PC_DEF = 16'h0000;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int MM_MSB  = 27;
   localparam int MM_LSB  = 24;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

   localparam logic [3:0] OP_NOOP = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_STR  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_BRA  = 4'h8;
   localparam logic [3:0] OP_BRR  = 4'h9;
   localparam logic [3:0] OP_BNE  = 4'hA;
   localparam logic [3:0] OP_BNR  = 4'hB;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_REQ  = 2'd1,
      F_DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/sisc_pc_reg.sv
// Program counter with next-PC selection: hold, PC+1, absolute or
// PC-relative branch target taken from the IR immediate.
module sisc_pc_reg
   import sisc_fetch_unit_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_rst,
   input  logic             pc_write,
   input  logic             pc_sel,
   input  logic             br_sel,
   input  logic [IMM_W-1:0] imm,
   output logic [AW-1:0]    pc
);

   logic [AW-1:0] pc_q, pc_d, target;

   // Immediate is taken as-is (no sign extension); sums wrap mod 2^AW.
   always_comb begin
      target = br_sel ? AW'(imm) : pc_q + AW'(imm);
      pc_d   = pc_q;
      if (pc_rst)
         pc_d = RST_PC;
      else if (pc_write)
         pc_d = pc_sel ? target : pc_q + AW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RST_PC;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, one-entry instruction prefetch buffer, imem request
// FSM and the instruction register feeding ctrl/datapath decode.
module sisc_fetch_unit
   import sisc_fetch_unit_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int IW = IW_DEF,
   parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pc_rst,
   input  logic          pc_write,
   input  logic          pc_sel,
   input  logic          br_sel,
   input  logic          ir_load,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic [AW-1:0] pc_out,
   output logic [IW-1:0] ir,
   output logic [3:0]    opcode,
   output logic [3:0]    mm,
   output logic          ir_valid
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] req_addr_q, req_addr_d;
   logic [AW-1:0] pf_addr_q, pf_addr_d;
   logic [IW-1:0] pf_data_q, pf_data_d;
   logic          pf_valid_q, pf_valid_d;
   logic          ld_pend_q, ld_pend_d;
   logic [AW-1:0] ld_addr_q, ld_addr_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          ir_valid_q, ir_valid_d;
   logic          usable, ack, req_hit, pend_hit, new_ld;

   sisc_pc_reg #(.AW(AW), .RST_PC(RST_PC)) u_pc (
      .clk      (clk),
      .rst      (rst),
      .pc_rst   (pc_rst),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .imm      (ir_q[IMM_MSB:IMM_LSB]),
      .pc       (pc_out)
   );

   assign usable   = pf_valid_q && (pf_addr_q == pc_out);
   assign ack      = imem_ack && (state_q != F_IDLE);
   assign req_hit  = (state_q == F_REQ) && (req_addr_q == pc_out);
   assign pend_hit = ld_pend_q && (ld_addr_q == req_addr_q);
   assign new_ld   = ir_load && !ld_pend_q;

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      pf_addr_d  = pf_addr_q;
      pf_data_d  = pf_data_q;
      pf_valid_d = pf_valid_q;
      ld_pend_d  = ld_pend_q;
      ld_addr_d  = ld_addr_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      if (pc_rst) begin
         ir_d       = '0;
         ir_valid_d = 1'b0;
         pf_valid_d = 1'b0;
         ld_pend_d  = 1'b0;
         // An in-flight request cannot be withdrawn; let it finish and discard it.
         state_d    = (state_q != F_IDLE && !ack) ? F_DROP : F_IDLE;
      end else begin
         if (new_ld) begin
            if (usable) begin
               ir_d       = pf_data_q;
               ir_valid_d = 1'b1;
               pf_valid_d = 1'b0;
            end else if (req_hit && ack) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
            end else begin
               ir_valid_d = 1'b0;
               ld_pend_d  = 1'b1;
               ld_addr_d  = pc_out;
            end
         end
         unique case (state_q)
            F_IDLE: begin
               // A pending load owns the next request, even if PC has moved on.
               if (ld_pend_q) begin
                  state_d    = F_REQ;
                  req_addr_d = ld_addr_q;
               end else if (!usable && (new_ld || !pc_write)) begin
                  state_d    = F_REQ;
                  req_addr_d = pc_out;
               end
            end
            F_REQ: begin
               if (ack) begin
                  state_d = F_IDLE;
                  if (pend_hit) begin
                     ir_d       = imem_rdata;
                     ir_valid_d = 1'b1;
                     ld_pend_d  = 1'b0;
                  end else if (!(new_ld && req_hit)) begin
                     pf_addr_d  = req_addr_q;
                     pf_data_d  = imem_rdata;
                     pf_valid_d = 1'b1;
                  end
               end else if (pc_write && !pend_hit && !(new_ld && req_hit)) begin
                  state_d = F_DROP;
               end
            end
            F_DROP: begin
               if (ack) state_d = F_IDLE;
            end
            default: state_d = F_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= F_IDLE;
         req_addr_q <= RST_PC;
         pf_addr_q  <= '0;
         pf_data_q  <= '0;
         pf_valid_q <= 1'b0;
         ld_pend_q  <= 1'b0;
         ld_addr_q  <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         pf_addr_q  <= pf_addr_d;
         pf_data_q  <= pf_data_d;
         pf_valid_q <= pf_valid_d;
         ld_pend_q  <= ld_pend_d;
         ld_addr_q  <= ld_addr_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign imem_req  = (state_q != F_IDLE);
   assign imem_addr = req_addr_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign opcode    = ir_q[OPC_MSB:OPC_LSB];
   assign mm        = ir_q[MM_MSB:MM_LSB];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: variable-latency imem model, IR scoreboard,
// branch/PC vector table and hand-written drop/reset sequences.
module tb_sisc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, ir_load = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [15:0] pc_out;
   logic [31:0] ir;
   logic [3:0]  opcode, mm;
   logic        ir_valid;

   sisc_fetch_unit dut (
      .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
      .br_sel(br_sel), .ir_load(ir_load), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out), .ir(ir),
      .opcode(opcode), .mm(mm), .ir_valid(ir_valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:65535];
   logic [31:0] sb [$];

   // imem model: acks `lat` cycles after a request is first seen
   int          lat = 0;
   int          wait_cnt = 0;
   int          n_req = 0;
   int          addr_err = 0;
   logic        in_req = 1'b0;
   logic [15:0] held_addr = '0;
   logic [15:0] last_req_addr = '0;

   always @(negedge clk) begin
      imem_ack = 1'b0;
      if (imem_req) begin
         if (!in_req) begin
            in_req = 1'b1;
            wait_cnt = 0;
            held_addr = imem_addr;
            last_req_addr = imem_addr;
            n_req++;
         end else if (imem_addr != held_addr) begin
            addr_err++;
         end
         if (wait_cnt >= lat) begin
            imem_ack = 1'b1;
            imem_rdata = mem[imem_addr];
            in_req = 1'b0;
         end else begin
            wait_cnt++;
         end
      end else begin
         in_req = 1'b0;
      end
   end

   typedef struct {
      logic [15:0] addr;
      logic [31:0] word;
      logic        ps;
      logic        bs;
      logic [3:0]  opc;
      logic [3:0]  mmv;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; ir_load = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ir_valid", 32'(ir_valid), 32'h0);
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge: load IR at PC `a`, optionally updating PC in the same cycle.
   task automatic load_ir(input logic [15:0] a, input logic pw, input logic ps,
                          input logic bs, output int waited);
      logic [31:0] e;
      chk("pc_pre", 32'(pc_out), 32'(a));
      sb.push_back(mem[a]);
      ir_load = 1'b1; pc_write = pw; pc_sel = ps; br_sel = bs;
      @(negedge clk);
      ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
      waited = 0;
      while (!ir_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      e = sb.pop_front();
      if (!ir_valid) chk("ir_valid_timeout", 32'(ir_valid), 32'h1);
      else           chk("ir_sb", ir, e);
   endtask

   task automatic branch(input logic ps, input logic bs);
      pc_write = 1'b1; pc_sel = ps; br_sel = bs;
      @(negedge clk);
      pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
   endtask

   task automatic wait_req(input logic [15:0] a, input string nm);
      int n = 0;
      while (!(imem_req && imem_addr == a) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(imem_req && imem_addr == a), 32'h1);
   endtask

   task automatic wait_new_req(input logic [15:0] a, input string nm);
      int snap = n_req;
      int n = 0;
      while (n_req == snap && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_seen"}, 32'(n_req != snap), 32'h1);
      chk(nm, 32'(last_req_addr), 32'(a));
   endtask

   initial begin
      int w;
      int snap;
      tbl[0] = '{16'h0001, 32'hC100_0010, 1'b1, 1'b1, 4'hC, 4'h1, 16'h0010};
      tbl[1] = '{16'h0010, 32'hD200_0004, 1'b1, 1'b0, 4'hD, 4'h2, 16'h0014};
      tbl[2] = '{16'h0014, 32'h5300_00A0, 1'b1, 1'b1, 4'h5, 4'h3, 16'h00A0};
      tbl[3] = '{16'h00A0, 32'hC000_FFFF, 1'b1, 1'b1, 4'hC, 4'h0, 16'hFFFF};
      tbl[4] = '{16'hFFFF, 32'h1400_0000, 1'b0, 1'b0, 4'h1, 4'h4, 16'h0000};
      tbl[5] = '{16'h0000, 32'h8012_3000, 1'b1, 1'b0, 4'h8, 4'h0, 16'h3000};
      tbl[6] = '{16'h3000, 32'hE500_F000, 1'b1, 1'b0, 4'hE, 4'h5, 16'h2000};
      tbl[7] = '{16'h2000, 32'h2600_0000, 1'b0, 1'b0, 4'h2, 4'h6, 16'h2001};
      for (int i = 0; i < 65536; i++) mem[i] = 32'hA500_0000 | 32'(i);
      for (int i = 0; i < 8; i++) mem[tbl[i].addr] = tbl[i].word;

      // zero-wait memory: prefetched word loads with no extra latency
      lat = 0;
      do_reset();
      repeat (3) @(negedge clk);
      load_ir(16'h0000, 1'b1, 1'b0, 1'b0, w);
      chk("zero_lat_wait", 32'(w), 32'h0);
      chk("zero_lat_opcode", 32'(opcode), 32'h8);
      chk("zero_lat_mm", 32'(mm), 32'h0);
      chk("zero_lat_pc", 32'(pc_out), 32'h1);

      // branch / PC-update vector table, latency varied per row
      for (int i = 0; i < 8; i++) begin
         lat = i % 3;
         load_ir(tbl[i].addr, 1'b0, 1'b0, 1'b0, w);
         chk("tbl_opcode", 32'(opcode), 32'(tbl[i].opc));
         chk("tbl_mm", 32'(mm), 32'(tbl[i].mmv));
         branch(tbl[i].ps, tbl[i].bs);
         chk("tbl_pc", 32'(pc_out), 32'(tbl[i].exp_pc));
      end

      // 3-cycle latency, ir_load while the matching request is in flight
      lat = 3;
      do_reset();
      wait_req(16'h0000, "lat3_req0");
      sb.push_back(mem[0]);
      ir_load = 1'b1; pc_write = 1'b1;
      @(negedge clk);
      ir_load = 1'b0; pc_write = 1'b0;
      chk("lat3_ir_valid_low", 32'(ir_valid), 32'h0);
      snap = n_req;
      w = 0;
      while (!ir_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("lat3_ir", ir, sb.pop_front());
      chk("lat3_no_dup_req", 32'(n_req), 32'(snap));
      chk("lat3_pc", 32'(pc_out), 32'h1);

      // relative branch drops the in-flight refetch of 0x0010
      load_ir(16'h0001, 1'b0, 1'b0, 1'b0, w);
      branch(1'b1, 1'b1);
      chk("drop_pc_abs", 32'(pc_out), 32'h0010);
      load_ir(16'h0010, 1'b0, 1'b0, 1'b0, w);
      wait_req(16'h0010, "drop_inflight");
      branch(1'b1, 1'b0);
      chk("drop_pc_rel", 32'(pc_out), 32'h0014);
      wait_new_req(16'h0014, "drop_next_req");
      load_ir(16'h0014, 1'b1, 1'b0, 1'b0, w);
      chk("drop_pc_inc", 32'(pc_out), 32'h0015);

      // pc_rst while a request is outstanding
      lat = 4;
      wait_req(16'h0015, "pcrst_inflight");
      pc_rst = 1'b1;
      @(negedge clk);
      pc_rst = 1'b0;
      chk("pcrst_pc", 32'(pc_out), 32'h0);
      chk("pcrst_ir", ir, 32'h0);
      chk("pcrst_ir_valid", 32'(ir_valid), 32'h0);
      wait_new_req(16'h0000, "pcrst_fresh_req");
      load_ir(16'h0000, 1'b1, 1'b0, 1'b0, w);

      // asynchronous rst in the middle of a request
      lat = 5;
      wait_req(16'h0001, "arst_inflight");
      #2 rst = 1'b1;
      #1;
      chk("arst_imem_req", 32'(imem_req), 32'h0);
      chk("arst_pc", 32'(pc_out), 32'h0);
      chk("arst_ir", ir, 32'h0);
      chk("arst_ir_valid", 32'(ir_valid), 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("arst_hold_req", 32'(imem_req), 32'h0);
      end
      rst = 1'b0;
      wait_new_req(16'h0000, "arst_release_req");

      chk("addr_stable", 32'(addr_err), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
